// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: round-robin sharing of one instruction-memory port with locked grant and watchdog abort
module imem_port_arbiter #(
  parameter int XLEN = 32,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            up_req,
  input  logic [NUM_REQ*XLEN-1:0]                       up_addr,
  output logic [XLEN-1:0]                               up_rdata,
  output logic [NUM_REQ-1:0]                            up_ready,
  output logic                                          mem_req,
  output logic [XLEN-1:0]                               mem_addr,
  input  logic [XLEN-1:0]                               mem_rdata,
  input  logic                                          mem_ready,
  output logic                                          timeout_err,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] timeout_id,
  output logic                                          busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int WW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW:0] NR = (IW + 1)'(NUM_REQ);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, grant, sel, off;
  logic [IW:0] sum;
  logic [NUM_REQ-1:0] rot;
  logic [XLEN-1:0] sel_addr;
  logic [WW-1:0] wdog;
  logic done, abort;
  // rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner's offset
  always_comb begin
    rot = NUM_REQ'({up_req, up_req} >> rr_ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
    sum = {1'b0, rr_ptr} + {1'b0, off};
    sel = IW'(sum >= NR ? sum - NR : sum);
    sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) if (sel == IW'(k)) sel_addr = up_addr[k*XLEN +: XLEN];
  end
  assign done = state == BUSY && mem_ready;
  assign abort = TIMEOUT_CYCLES > 0 && state == BUSY && !mem_ready && wdog == WLAST;
  assign up_ready = (done || abort) ? NUM_REQ'(1) << grant : '0;
  assign up_rdata = done ? mem_rdata : '0;
  assign timeout_err = abort;
  assign timeout_id = abort ? grant : '0;
  assign busy = state == BUSY;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      wdog <= '0;
    end else if (state == IDLE) begin
      if (|up_req) begin
        state <= BUSY;
        grant <= sel;
        mem_addr <= sel_addr;
        mem_req <= 1'b1;
        wdog <= '0;
      end
    end else begin
      wdog <= wdog + 1'b1;
      if (done || abort) begin
        state <= IDLE;
        mem_req <= 1'b0;
        rr_ptr <= grant == IW'(NUM_REQ - 1) ? '0 : grant + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: scenario tasks with a scoreboard of expected completions
module tb_imem_port_arbiter;
  localparam int XLEN = 32, NR = 2, TO = 8;
  logic clk = 0, rst = 1;
  logic [NR-1:0] up_req = '0;
  logic [NR*XLEN-1:0] up_addr = '0;
  logic [XLEN-1:0] up_rdata, mem_addr;
  logic [NR-1:0] up_ready;
  logic mem_req, timeout_err, busy;
  logic [XLEN-1:0] mem_rdata = '0;
  logic mem_ready = 0;
  logic [0:0] timeout_id;
  int total = 0, bad = 0;
  typedef struct packed {logic [1:0] rdy; logic [31:0] data; logic terr; logic tid;} exp_t;
  exp_t q[$];
  exp_t e;

  imem_port_arbiter #(.XLEN(XLEN), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .up_req(up_req), .up_addr(up_addr), .up_rdata(up_rdata),
    .up_ready(up_ready), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .timeout_err(timeout_err), .timeout_id(timeout_id), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task tick;
    @(negedge clk);
  endtask

  task do_reset;
    rst = 1; up_req = '0; mem_ready = 0; mem_rdata = '0;
    tick; tick;
    rst = 0;
  endtask

  task test_reset;
    rst = 1;
    tick; tick; #1;
    total++;
    if ({mem_req, busy, mem_addr} !== {1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_mem: got req=%b busy=%b addr=%h want 0 0 0", mem_req, busy, mem_addr);
    end
    total++;
    if ({up_ready, up_rdata, timeout_err, timeout_id} !== 36'h0) begin
      bad++; $display("FAIL reset_up: got rdy=%b data=%h terr=%b tid=%b want all 0", up_ready, up_rdata, timeout_err, timeout_id);
    end
    rst = 0;
  endtask

  task test_single;
    tick;
    up_addr[31:0] = 32'h100; up_req = 2'b01;
    q.push_back(exp_t'{2'b01, 32'hDEADBEEF, 1'b0, 1'b0});
    #1; total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL single_early: got mem_req=%b want 0", mem_req); end
    tick; #1; total++;
    if ({mem_req, busy, mem_addr} !== {1'b1, 1'b1, 32'h100}) begin
      bad++; $display("FAIL single_grant: got req=%b busy=%b addr=%h want 1 1 00000100", mem_req, busy, mem_addr);
    end
    tick; #1; total++;
    if ({mem_req, up_ready} !== 3'b100) begin bad++; $display("FAIL single_wait: got req=%b rdy=%b want 1 00", mem_req, up_ready); end
    tick; mem_ready = 1; mem_rdata = 32'hDEADBEEF; #1; total++;
    if (q.size() == 0) begin bad++; $display("FAIL single_done: got completion, want none queued"); end
    else begin
      e = q.pop_front();
      if ({up_ready, up_rdata, timeout_err, timeout_id} !== e) begin bad++; $display("FAIL single_done: got %h want %h", {up_ready, up_rdata, timeout_err, timeout_id}, e); end
    end
    tick; mem_ready = 0; mem_rdata = '0; up_req = '0; #1; total++;
    if ({up_ready, mem_req, busy} !== 4'b0) begin bad++; $display("FAIL single_after: got rdy=%b req=%b busy=%b want 0", up_ready, mem_req, busy); end
  endtask

  task test_round_robin;
    do_reset;
    up_addr = {32'h4, 32'h0}; up_req = 2'b11;
    for (int k = 0; k < 4; k++) q.push_back(exp_t'{(k % 2) ? 2'b10 : 2'b01, 32'hA0 + k, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      tick; #1; total++;
      if ({mem_req, mem_addr} !== {1'b1, (k % 2) ? 32'h4 : 32'h0}) begin
        bad++; $display("FAIL rr_grant%0d: got req=%b addr=%h want 1 %h", k, mem_req, mem_addr, (k % 2) ? 32'h4 : 32'h0);
      end
      tick; mem_ready = 1; mem_rdata = 32'hA0 + k; #1; total++;
      if (q.size() == 0) begin bad++; $display("FAIL rr_done%0d: got completion, want none queued", k); end
      else begin
        e = q.pop_front();
        if ({up_ready, up_rdata, timeout_err, timeout_id} !== e) begin bad++; $display("FAIL rr_done%0d: got %h want %h", k, {up_ready, up_rdata, timeout_err, timeout_id}, e); end
      end
      tick; mem_ready = 0; #1; total++;
      if ({mem_req, busy} !== 2'b00) begin bad++; $display("FAIL rr_idle%0d: got req=%b busy=%b want 0 0", k, mem_req, busy); end
    end
    up_req = '0;
  endtask

  task test_addr_stable;
    do_reset;
    up_addr[31:0] = 32'h100; up_req = 2'b01;
    q.push_back(exp_t'{2'b01, 32'h12345678, 1'b0, 1'b0});
    tick; up_addr[31:0] = 32'h200; #1; total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin bad++; $display("FAIL addr_hold1: got req=%b addr=%h want 1 00000100", mem_req, mem_addr); end
    tick; #1; total++;
    if (mem_addr !== 32'h100) begin bad++; $display("FAIL addr_hold2: got %h want 00000100", mem_addr); end
    tick; mem_ready = 1; mem_rdata = 32'h12345678; #1; total++;
    if (q.size() == 0) begin bad++; $display("FAIL addr_done: got completion, want none queued"); end
    else begin
      e = q.pop_front();
      if ({up_ready, up_rdata, timeout_err, timeout_id, mem_addr} !== {e, 32'h100}) begin
        bad++; $display("FAIL addr_done: got %h addr=%h want %h addr=00000100", {up_ready, up_rdata, timeout_err, timeout_id}, mem_addr, e);
      end
    end
    tick; mem_ready = 0; mem_rdata = '0; up_req = '0;
  endtask

  task test_timeout;
    do_reset;
    up_addr = {32'h40, 32'h80}; up_req = 2'b10;
    q.push_back(exp_t'{2'b10, 32'h0, 1'b1, 1'b1});
    tick; #1; total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin bad++; $display("FAIL to_grant: got req=%b addr=%h want 1 00000040", mem_req, mem_addr); end
    for (int i = 2; i < TO; i++) begin
      tick; #1; total++;
      if ({timeout_err, up_ready} !== 3'b000) begin bad++; $display("FAIL to_early%0d: got terr=%b rdy=%b want 0 00", i, timeout_err, up_ready); end
    end
    tick; up_req = 2'b11; #1; total++;
    if (q.size() == 0) begin bad++; $display("FAIL to_abort: got abort, want none queued"); end
    else begin
      e = q.pop_front();
      if ({up_ready, up_rdata, timeout_err, timeout_id} !== e) begin bad++; $display("FAIL to_abort: got %h want %h", {up_ready, up_rdata, timeout_err, timeout_id}, e); end
    end
    tick; up_req = 2'b01; #1; total++;
    if ({mem_req, busy, timeout_err} !== 3'b000) begin bad++; $display("FAIL to_release: got req=%b busy=%b terr=%b want 0 0 0", mem_req, busy, timeout_err); end
    q.push_back(exp_t'{2'b01, 32'hCAFEF00D, 1'b0, 1'b0});
    tick; #1; total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin bad++; $display("FAIL to_next_grant: got req=%b addr=%h want 1 00000080", mem_req, mem_addr); end
    for (int i = 2; i < TO; i++) tick;
    tick; mem_ready = 1; mem_rdata = 32'hCAFEF00D; #1; total++;
    if (q.size() == 0) begin bad++; $display("FAIL to_late_ready: got completion, want none queued"); end
    else begin
      e = q.pop_front();
      if ({up_ready, up_rdata, timeout_err, timeout_id} !== e) begin bad++; $display("FAIL to_late_ready: got %h want %h", {up_ready, up_rdata, timeout_err, timeout_id}, e); end
    end
    tick; mem_ready = 0; mem_rdata = '0; up_req = '0; #1; total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL to_end_idle: got busy=%b want 0", busy); end
  endtask

  task test_reset_mid;
    up_addr[63:32] = 32'h500; up_req = 2'b10;
    tick; #1; total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin bad++; $display("FAIL rm_grant: got req=%b addr=%h want 1 00000500", mem_req, mem_addr); end
    tick; rst = 1;
    tick; rst = 0; up_req = '0; #1; total++;
    if ({mem_req, busy} !== 2'b00) begin bad++; $display("FAIL rm_cleared: got req=%b busy=%b want 0 0", mem_req, busy); end
    mem_ready = 1; mem_rdata = 32'h55; #1; total++;
    if ({up_ready, up_rdata} !== 34'h0) begin bad++; $display("FAIL rm_late_ready: got rdy=%b data=%h want 0 0", up_ready, up_rdata); end
    tick; mem_ready = 0; mem_rdata = '0; up_req = 2'b11;
    q.push_back(exp_t'{2'b01, 32'h77, 1'b0, 1'b0});
    tick; #1; total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin bad++; $display("FAIL rm_first: got req=%b addr=%h want 1 00000080", mem_req, mem_addr); end
    tick; mem_ready = 1; mem_rdata = 32'h77; #1; total++;
    if (q.size() == 0) begin bad++; $display("FAIL rm_done: got completion, want none queued"); end
    else begin
      e = q.pop_front();
      if ({up_ready, up_rdata, timeout_err, timeout_id} !== e) begin bad++; $display("FAIL rm_done: got %h want %h", {up_ready, up_rdata, timeout_err, timeout_id}, e); end
    end
    tick; mem_ready = 0; mem_rdata = '0; up_req = '0;
  endtask

  task test_stray_ready;
    tick; up_req = '0; mem_ready = 1; mem_rdata = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      #1; total++;
      if ({up_ready, up_rdata, busy, mem_req} !== 36'h0) begin
        bad++; $display("FAIL stray%0d: got rdy=%b data=%h busy=%b req=%b want all 0", i, up_ready, up_rdata, busy, mem_req);
      end
      tick;
    end
    mem_ready = 0; mem_rdata = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_addr_stable;
    test_timeout;
    test_reset_mid;
    test_stray_ready;
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
